instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the decode stage: accepts compact instruction descriptors (operation kind plus register and immediate fields) over a valid/ready handshake.
- Encodes each descriptor into a 32-bit MIPS instruction word covering exactly the instruction set the pipeline decodes.
- Writes each word sequentially into instruction memory through a single write port.
- Used as the program loader for bring-up and for self-checking pipeline tests.

Parameters:
- AW, 8, instruction-memory word-address width.
- DEPTH, 256, maximum number of words loaded per session; 1 ≤ DEPTH ≤ 2^AW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse: begin a load session at word address 0.
- finish  input  1  pulse: end the current session.
- op_valid  input  1  descriptor valid.
- op_ready  output  1  descriptor accepted when op_valid && op_ready at a rising edge.
- op_kind  input  5  operation code, table below.
- rs  input  5  source register field.
- rt  input  5  target register field.
- rd  input  5  destination register field.
- imm  input  16  immediate or branch offset.
- imem_we  output  1  instruction-memory write enable.
- imem_addr  output  AW  word address.
- imem_wdata  output  32  encoded instruction.
- word_count  output  AW+1  words written this session.
- busy  output  1  session active.
- done  output  1  one-cycle pulse at session end.
- err_kind  output  1  sticky: an undefined op_kind was accepted.
- err_full  output  1  sticky: op_valid was asserted while the session was full.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including both sticky errors; imem_addr = 0, word_count = 0.
  - A reset mid-session abandons the session; any pending write is dropped.
- States:
  - IDLE: op_ready=0, busy=0. start → ACCEPT; word_count := 0; both errors cleared.
  - ACCEPT: busy=1; op_ready = (word_count < DEPTH).
    - Handshake with a defined kind → WRITE; encoded word and address registered.
    - Handshake with an undefined kind → err_kind := 1, nothing written, stay in ACCEPT (descriptor consumed).
  - WRITE: exactly one cycle; imem_we=1, imem_addr = word_count[AW-1:0], imem_wdata valid, op_ready=0. Next edge: word_count += 1, → ACCEPT.
  - DONE: one cycle; done=1, busy=0 → IDLE.
- Session end:
  - finish in ACCEPT → DONE.
  - finish in WRITE → the write completes, then → DONE.
  - finish takes priority over a same-cycle handshake: that descriptor is not accepted.
- Throughput and latency:
  - One word per 2 cycles.
  - Write occurs in the cycle after the handshake.
  - imem_addr and imem_wdata hold their last values outside WRITE.
- Full condition:
  - word_count == DEPTH: op_ready=0; op_valid=1 sets err_full.
  - Session remains in ACCEPT until finish.
  - No address wrap-around.
- start while busy: ignored. start in IDLE together with op_valid: the descriptor is not accepted that cycle.
- Encoding:
  - R-type = {6'b0, rs, rt, rd, 5'b0, funct}.
  - I-type = {opcode, rs, rt, imm}.
- op_kind table (kind: instruction, funct or opcode):
  - R-type, funct: 0 add 100000; 1 sub 100010; 2 and 100100; 3 or 100101; 4 xor 100110; 5 addu 100001; 6 subu 100011; 7 nor 100111; 8 slt 101010; 9 sltu 101011; 10 sllv 000100; 11 srav 000111; 12 srlv 000110.
  - I-type, opcode: 16 lw 100011; 17 sw 101011; 18 addi 001000; 19 andi 001100; 20 ori 001101; 21 xori 001110; 22 slti 001010; 23 sltiu 001011.
  - 24 lui 001111, rs forced to 0.
  - Branches: 25 beq 000100; 26 bgtz 000111, rt forced 0; 27 bltz 000001, rt forced 00000; 28 bgez 000001, rt forced 00001; 29 blez 000110, rt forced 0; 30 bne 000101.
  - Kinds 13–15 and 31 are undefined.
- Field forcing:
  - rd is ignored for I-type.
  - imm is ignored for R-type.

Test Plan:
- Reset, start, descriptor kind 0, rs=1, rt=2, rd=3 → next cycle imem_we=1, addr 0, wdata 0x00221820; word_count=1; op_ready low during WRITE.
- Kind 16 (lw) rs=4, rt=5, imm=0x0008 → 0x8C850008 at addr 1; kind 28 (bgez) rs=7, rt=9, imm=0xFFFF → 0x04E1FFFF (rt forced to 1).
- Kind 24 (lui) rs=31, rt=9, imm=0x1234 → 0x3C091234; kind 13 → no imem_we, err_kind=1, word_count unchanged, op_ready back high the next cycle.
- DEPTH=4: five back-to-back descriptors → four writes at addrs 0–3; op_ready stays 0; err_full=1; finish → done pulse, then IDLE; a new start clears both errors and word_count.
- finish asserted in the same cycle as a handshake in ACCEPT → descriptor not accepted, done the next cycle; finish during WRITE → write completes, then done.
- rst_n dropped asynchronously during WRITE → imem_we falls immediately; all outputs 0; state IDLE.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Program loader: encodes compact instruction descriptors into 32-bit MIPS words
// and writes them sequentially into instruction memory, one word every two cycles.
module instr_encoder_loader #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          finish,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [4:0]    op_kind,
    input  logic [4:0]    rs,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    input  logic [15:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   word_count,
    output logic          busy,
    output logic          done,
    output logic          err_kind,
    output logic          err_full
);

    localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_addr, w_addr_d;
    logic [31:0]   r_wdata, w_wdata_d;
    logic [AW:0]   r_count, w_count_d;
    logic          r_err_kind, w_err_kind_d;
    logic          r_err_full, w_err_full_d;

    logic          w_not_full;
    logic          w_defined;
    logic          w_rtype;
    logic [5:0]    w_funct;
    logic [5:0]    w_opcode;
    logic [4:0]    w_rs;
    logic [4:0]    w_rt;
    logic [31:0]   w_word;

    // Encoder: R-type selects funct, I-type selects opcode; some kinds force rs/rt.
    always_comb begin
        w_defined = 1'b1;
        w_rtype   = 1'b0;
        w_funct   = 6'b000000;
        w_opcode  = 6'b000000;
        w_rs      = rs;
        w_rt      = rt;
        case (op_kind)
            5'd0:  begin w_rtype = 1'b1; w_funct = 6'b100000; end
            5'd1:  begin w_rtype = 1'b1; w_funct = 6'b100010; end
            5'd2:  begin w_rtype = 1'b1; w_funct = 6'b100100; end
            5'd3:  begin w_rtype = 1'b1; w_funct = 6'b100101; end
            5'd4:  begin w_rtype = 1'b1; w_funct = 6'b100110; end
            5'd5:  begin w_rtype = 1'b1; w_funct = 6'b100001; end
            5'd6:  begin w_rtype = 1'b1; w_funct = 6'b100011; end
            5'd7:  begin w_rtype = 1'b1; w_funct = 6'b100111; end
            5'd8:  begin w_rtype = 1'b1; w_funct = 6'b101010; end
            5'd9:  begin w_rtype = 1'b1; w_funct = 6'b101011; end
            5'd10: begin w_rtype = 1'b1; w_funct = 6'b000100; end
            5'd11: begin w_rtype = 1'b1; w_funct = 6'b000111; end
            5'd12: begin w_rtype = 1'b1; w_funct = 6'b000110; end
            5'd16: w_opcode = 6'b100011;
            5'd17: w_opcode = 6'b101011;
            5'd18: w_opcode = 6'b001000;
            5'd19: w_opcode = 6'b001100;
            5'd20: w_opcode = 6'b001101;
            5'd21: w_opcode = 6'b001110;
            5'd22: w_opcode = 6'b001010;
            5'd23: w_opcode = 6'b001011;
            5'd24: begin w_opcode = 6'b001111; w_rs = 5'd0; end
            5'd25: w_opcode = 6'b000100;
            5'd26: begin w_opcode = 6'b000111; w_rt = 5'd0; end
            5'd27: begin w_opcode = 6'b000001; w_rt = 5'd0; end
            5'd28: begin w_opcode = 6'b000001; w_rt = 5'd1; end
            5'd29: begin w_opcode = 6'b000110; w_rt = 5'd0; end
            5'd30: w_opcode = 6'b000101;
            default: w_defined = 1'b0;
        endcase
        w_word = w_rtype ? {6'b000000, rs, rt, rd, 5'b00000, w_funct}
                         : {w_opcode, w_rs, w_rt, imm};
    end

    assign w_not_full = (r_count < DepthC);

    always_comb begin
        w_state_d    = r_state;
        w_addr_d     = r_addr;
        w_wdata_d    = r_wdata;
        w_count_d    = r_count;
        w_err_kind_d = r_err_kind;
        w_err_full_d = r_err_full;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d    = StAccept;
                    w_count_d    = '0;
                    w_err_kind_d = 1'b0;
                    w_err_full_d = 1'b0;
                end
            end
            StAccept: begin
                if (op_valid && !w_not_full) begin
                    w_err_full_d = 1'b1;
                end
                // finish wins over a same-cycle handshake
                if (finish) begin
                    w_state_d = StDone;
                end else if (op_valid && w_not_full) begin
                    if (w_defined) begin
                        w_state_d = StWrite;
                        w_addr_d  = r_count[AW-1:0];
                        w_wdata_d = w_word;
                    end else begin
                        w_err_kind_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                w_count_d = r_count + 1'b1;
                w_state_d = finish ? StDone : StAccept;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_err_kind <= 1'b0;
            r_err_full <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_count    <= w_count_d;
            r_err_kind <= w_err_kind_d;
            r_err_full <= w_err_full_d;
        end
    end

    assign op_ready   = (r_state == StAccept) && w_not_full;
    assign imem_we    = (r_state == StWrite);
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign word_count = r_count;
    assign busy       = (r_state == StAccept) || (r_state == StWrite);
    assign done       = (r_state == StDone);
    assign err_kind   = r_err_kind;
    assign err_full   = r_err_full;

endmodule
